// File: rtl/flab_pkg.sv
// Shared types and helpers for the FLAB 8x8 bird game logic.
package flab_pkg;

  typedef enum logic [1:0] {IDLE, RISE, FALL, DEAD} bird_state_t;

  localparam int ROWS  = 8;
  localparam int ROW_W = $clog2(ROWS);

  function automatic logic [ROWS-1:0] row_onehot(input logic [ROW_W-1:0] r);
    logic [ROWS-1:0] one;
    one = {{(ROWS-1){1'b0}}, 1'b1};
    return one << r;
  endfunction

endpackage

// File: rtl/bird_fall_timer.sv
// Modulo-FALL_DIV tick counter for gravity; step is high on the count that moves the bird down.
module bird_fall_timer #(
  parameter int FALL_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic step
);

  localparam int CW = (FALL_DIV > 1) ? $clog2(FALL_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(FALL_DIV - 1);

  logic [CW-1:0] cnt_q;

  assign step = (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= step ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/bird_motion_ctrl.sv
// Bird row physics and alive/dead state for the FLAB matrix.
// Optional build macro BIRD_CEILING_KILL_EN makes climbing past row 7 lethal.
module bird_motion_ctrl
  import flab_pkg::*;
#(
  parameter int RISE_TICKS = 2,
  parameter int FALL_DIV   = 2,
  parameter int START_ROW  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick,
  input  logic            start,
  input  logic            push,
  input  logic            collide,
  output logic [ROWS-1:0] bird_head,
  output logic [ROWS-1:0] bird_tail,
  output logic            alive,
  output logic            game_over
);

  localparam int RC_W = (RISE_TICKS > 1) ? $clog2(RISE_TICKS) : 1;
  localparam logic [RC_W-1:0]  RISE_LAST = RC_W'(RISE_TICKS - 1);
  localparam logic [ROW_W-1:0] ROW_TOP   = ROW_W'(ROWS - 1);
  localparam logic [ROW_W-1:0] ROW_START = ROW_W'(START_ROW);

  bird_state_t      state_q;
  logic [ROW_W-1:0] row_q;
  logic [RC_W-1:0]  rise_cnt_q;
  logic             push_pend_q;
  logic [ROWS-1:0]  head_q;
  logic [ROWS-1:0]  tail_q;
  logic             alive_q;
  logic             game_over_q;

  logic             in_play;
  logic             flap;
  logic             up_now;
  logic             ceil_kill;
  logic [ROW_W-1:0] row_up;
  logic             fall_step;
  logic             fall_en;

  assign in_play = (state_q == RISE) || (state_q == FALL);
  // A push arriving in the same clk as the tick is honoured by that tick.
  assign flap    = push_pend_q || push;
  assign up_now  = flap || ((state_q == RISE) && (rise_cnt_q != '0));
  assign row_up  = (row_q == ROW_TOP) ? row_q : row_q + ROW_W'(1);
  assign fall_en = tick && (state_q == FALL) && !flap && !collide;

`ifdef BIRD_CEILING_KILL_EN
  assign ceil_kill = (row_q == ROW_TOP);
`else
  assign ceil_kill = 1'b0;
`endif

  // Counter only runs in FALL, so every entry into FALL starts from zero.
  bird_fall_timer #(.FALL_DIV(FALL_DIV)) u_fall_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q != FALL),
    .en    (fall_en),
    .step  (fall_step)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      row_q       <= ROW_START;
      rise_cnt_q  <= '0;
      push_pend_q <= 1'b0;
      head_q      <= row_onehot(ROW_START);
      tail_q      <= row_onehot(ROW_START);
      alive_q     <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DEAD: begin
          push_pend_q <= 1'b0;
          if (start) begin
            state_q     <= FALL;
            row_q       <= ROW_START;
            rise_cnt_q  <= '0;
            head_q      <= row_onehot(ROW_START);
            tail_q      <= row_onehot(ROW_START);
            alive_q     <= 1'b1;
            game_over_q <= 1'b0;
          end
        end
        RISE, FALL: begin
          if (collide) begin
            state_q     <= DEAD;
            push_pend_q <= 1'b0;
            alive_q     <= 1'b0;
            game_over_q <= 1'b1;
          end else if (tick) begin
            push_pend_q <= 1'b0;
            tail_q      <= head_q;
            if (up_now) begin
              if (ceil_kill) begin
                state_q     <= DEAD;
                alive_q     <= 1'b0;
                game_over_q <= 1'b1;
              end else begin
                state_q    <= RISE;
                row_q      <= row_up;
                head_q     <= row_onehot(row_up);
                rise_cnt_q <= flap ? RISE_LAST : rise_cnt_q - RC_W'(1);
              end
            end else if (state_q == RISE) begin
              state_q <= FALL;
            end else if (fall_step) begin
              if (row_q == '0) begin
                state_q     <= DEAD;
                alive_q     <= 1'b0;
                game_over_q <= 1'b1;
              end else begin
                row_q  <= row_q - ROW_W'(1);
                head_q <= row_onehot(row_q - ROW_W'(1));
              end
            end
          end else if (push) begin
            push_pend_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bird_head = head_q;
  assign bird_tail = tail_q;
  assign alive     = alive_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_bird_motion_ctrl.sv
// Directed bench for bird_motion_ctrl with default parameters (RISE_TICKS=2, FALL_DIV=2, START_ROW=4).
module tb_bird_motion_ctrl;
  import flab_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic       push = 1'b0;
  logic       collide = 1'b0;
  logic [7:0] bird_head;
  logic [7:0] bird_tail;
  logic       alive;
  logic       game_over;

  int total  = 0;
  int passed = 0;

  bird_motion_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .start     (start),
    .push      (push),
    .collide   (collide),
    .bird_head (bird_head),
    .bird_tail (bird_tail),
    .alive     (alive),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic t, input logic p, input logic s, input logic c);
    tick = t; push = p; start = s; collide = c;
    @(posedge clk);
    #1;
    tick = 1'b0; push = 1'b0; start = 1'b0; collide = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    cyc(0, 0, 0, 0);
    rst_n = 1'b1;
    chk("rst_head", 32'(bird_head), 32'h10);
    chk("rst_tail", 32'(bird_tail), 32'h10);
    chk("rst_alive", 32'(alive), 0);
    chk("rst_go", 32'(game_over), 0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));

    // Push is ignored while idle
    cyc(1, 1, 0, 0);
    chk("idle_state", 32'(dut.state_q), 32'(IDLE));
    chk("idle_pend", 32'(dut.push_pend_q), 0);
    chk("idle_head", 32'(bird_head), 32'h10);

    // 1: free fall to the floor
    cyc(0, 0, 1, 0);
    chk("t1_alive", 32'(alive), 1);
    chk("t1_state", 32'(dut.state_q), 32'(FALL));
    cyc(1, 0, 0, 0);
    chk("t1_tick1_head", 32'(bird_head), 32'h10);
    cyc(1, 0, 0, 0);
    chk("t1_tick2_head", 32'(bird_head), 32'h08);
    chk("t1_tick2_tail", 32'(bird_tail), 32'h10);
    repeat (6) cyc(1, 0, 0, 0);
    chk("t1_floor_head", 32'(bird_head), 32'h01);
    chk("t1_floor_tail", 32'(bird_tail), 32'h02);
    cyc(1, 0, 0, 0);
    chk("t1_floor_alive", 32'(alive), 1);
    cyc(1, 0, 0, 0);
    chk("t1_dead_go", 32'(game_over), 1);
    chk("t1_dead_alive", 32'(alive), 0);
    chk("t1_dead_head", 32'(bird_head), 32'h01);

    // 4: collide wins over tick and push at row 3, then restart
    cyc(0, 0, 1, 0);
    chk("t4_restart_head", 32'(bird_head), 32'h10);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("t4_row3_head", 32'(bird_head), 32'h08);
    cyc(1, 1, 0, 1);
    chk("t4_dead_go", 32'(game_over), 1);
    chk("t4_dead_head", 32'(bird_head), 32'h08);
    cyc(1, 0, 0, 0);
    chk("t4_frozen_head", 32'(bird_head), 32'h08);
    cyc(0, 0, 1, 0);
    chk("t4_start_head", 32'(bird_head), 32'h10);
    chk("t4_start_alive", 32'(alive), 1);
    chk("t4_start_go", 32'(game_over), 0);

    // 2: one push at row 4, then three ticks
    cyc(0, 1, 0, 0);
    chk("t2_nomove_head", 32'(bird_head), 32'h10);
    cyc(1, 0, 0, 0);
    chk("t2_tick1_head", 32'(bird_head), 32'h20);
    chk("t2_tick1_state", 32'(dut.state_q), 32'(RISE));
    cyc(1, 0, 0, 0);
    chk("t2_tick2_head", 32'(bird_head), 32'h40);
    cyc(1, 0, 0, 0);
    chk("t2_tick3_head", 32'(bird_head), 32'h40);
    chk("t2_tick3_tail", 32'(bird_tail), 32'h40);
    chk("t2_tick3_state", 32'(dut.state_q), 32'(FALL));

    // 3: flap on every tick from row 6 into the ceiling
    cyc(1, 1, 0, 0);
    chk("t3_row7_head", 32'(bird_head), 32'h80);
    chk("t3_row7_state", 32'(dut.state_q), 32'(RISE));
    cyc(1, 1, 0, 0);
    chk("t3_clamp_head", 32'(bird_head), 32'h80);
`ifdef BIRD_CEILING_KILL_EN
    chk("t3_ceil_go", 32'(game_over), 1);
    chk("t3_ceil_alive", 32'(alive), 0);
`else
    chk("t3_clamp_alive", 32'(alive), 1);
    chk("t3_clamp_go", 32'(game_over), 0);
    cyc(1, 1, 0, 0);
    chk("t3_clamp2_head", 32'(bird_head), 32'h80);
`endif

    // 5: push pulse between ticks is consumed once
    rst_n = 1'b0;
    cyc(0, 0, 0, 0);
    rst_n = 1'b1;
    cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("t5_pend", 32'(dut.push_pend_q), 1);
    cyc(1, 0, 0, 0);
    chk("t5_tick1_head", 32'(bird_head), 32'h20);
    chk("t5_tick1_pend", 32'(dut.push_pend_q), 0);
    cyc(1, 0, 0, 0);
    chk("t5_tick2_head", 32'(bird_head), 32'h40);
    cyc(1, 0, 0, 0);
    chk("t5_tick3_head", 32'(bird_head), 32'h40);
    chk("t5_tick3_state", 32'(dut.state_q), 32'(FALL));

    // 6: reset mid-game while rising at row 6
    rst_n = 1'b0;
    cyc(0, 0, 0, 0);
    rst_n = 1'b1;
    cyc(0, 0, 1, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    chk("t6_pre_head", 32'(bird_head), 32'h40);
    chk("t6_pre_state", 32'(dut.state_q), 32'(RISE));
    rst_n = 1'b0;
    cyc(0, 0, 0, 0);
    rst_n = 1'b1;
    chk("t6_head", 32'(bird_head), 32'h10);
    chk("t6_tail", 32'(bird_tail), 32'h10);
    chk("t6_state", 32'(dut.state_q), 32'(IDLE));
    chk("t6_alive", 32'(alive), 0);
    chk("t6_go", 32'(game_over), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
